// File: rtl/cpu_dma_tx_sched.sv
// Round-robin grant scheduler for CPU DMA TX queues sharing one DMA TX engine.
// One grant is held at a time until the engine reports done or the watchdog expires.
`timescale 1ns/1ps
module cpu_dma_tx_sched #(
  parameter int NUM_QUEUES          = 4,
  parameter int TX_WATCHDOG_TIMEOUT = 125000,
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int WW = $clog2(TX_WATCHDOG_TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_QUEUES-1:0] tx_req,
  input  logic                  tx_done,
  output logic [NUM_QUEUES-1:0] tx_grant,
  output logic                  tx_busy,
  output logic                  tx_timeout,
  output logic [QW-1:0]         tx_timeout_q
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [NUM_QUEUES-1:0] ONE_HOT_0 = {{(NUM_QUEUES-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]         WD_LOAD   = WW'(TX_WATCHDOG_TIMEOUT - 1);

  state_t                  state_r, state_s;
  logic [NUM_QUEUES-1:0]   grant_r, grant_s;
  logic [QW-1:0]           gq_r, gq_s;
  logic [QW-1:0]           last_q_r, last_q_s;
  logic [QW-1:0]           tq_r, tq_s;
  logic [QW-1:0]           winner_s, idx_s;
  logic [WW-1:0]           wd_r, wd_s;
  logic                    found_s;
  logic                    tmo_r, tmo_s;
  logic                    busy_r, busy_s;

  // Round-robin search starting just after the last winner, wrapping once.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      idx_s = QW'((int'(last_q_r) + i) % NUM_QUEUES);
      if (!found_s && tx_req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state logic: grant issue, hold, release on done, release on watchdog expiry.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    gq_s     = gq_r;
    last_q_s = last_q_r;
    wd_s     = wd_r;
    tmo_s    = 1'b0;
    tq_s     = '0;
    case (state_r)
      IDLE: begin
        if (enable && found_s) begin
          state_s  = ACTIVE;
          grant_s  = ONE_HOT_0 << winner_s;
          gq_s     = winner_s;
          last_q_s = winner_s;
          wd_s     = WD_LOAD;
        end else begin
          grant_s  = '0;
        end
      end
      ACTIVE: begin
        // done takes priority over an expiring watchdog
        if (tx_done) begin
          state_s = IDLE;
          grant_s = '0;
          wd_s    = '0;
        end else if (wd_r == '0) begin
          state_s = IDLE;
          grant_s = '0;
          wd_s    = '0;
          tmo_s   = 1'b1;
          tq_s    = gq_r;
        end else begin
          wd_s    = wd_r - WW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        wd_s    = '0;
      end
    endcase
    busy_s = |grant_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      gq_r     <= '0;
      last_q_r <= QW'(NUM_QUEUES - 1);
      wd_r     <= '0;
      tmo_r    <= 1'b0;
      tq_r     <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      gq_r     <= gq_s;
      last_q_r <= last_q_s;
      wd_r     <= wd_s;
      tmo_r    <= tmo_s;
      tq_r     <= tq_s;
      busy_r   <= busy_s;
    end
  end

  assign tx_grant     = grant_r;
  assign tx_busy      = busy_r;
  assign tx_timeout   = tmo_r;
  assign tx_timeout_q = tq_r;

endmodule

// File: tb/tb_cpu_dma_tx_sched.sv
// Scoreboard bench for cpu_dma_tx_sched: directed stimulus pushes expected grant
// start/end events; a negedge monitor observes the grant bus and compares.
`timescale 1ns/1ps
module tb_cpu_dma_tx_sched;

  logic       clk = 1'b0;
  logic       reset, enable, tx_done;
  logic [3:0] tx_req, tx_grant;
  logic       tx_busy, tx_timeout;
  logic [1:0] tx_timeout_q;

  cpu_dma_tx_sched #(.NUM_QUEUES(4), .TX_WATCHDOG_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tx_req(tx_req), .tx_done(tx_done),
    .tx_grant(tx_grant), .tx_busy(tx_busy), .tx_timeout(tx_timeout),
    .tx_timeout_q(tx_timeout_q)
  );

  always #5 clk = ~clk;

  // kind 0 = grant start, 1 = grant end; -1 in len/gap means don't care
  typedef struct {int kind; int grant; int len; int gap; int tmo; int tq;} ev_t;
  ev_t exp_q[$];

  int nvec = 0;
  int nmis = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    nvec++;
    if (got != expv) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic push(input int kind, input int grant, input int len, input int gap,
                      input int tmo, input int tq);
    ev_t e;
    e.kind = kind; e.grant = grant; e.len = len; e.gap = gap; e.tmo = tmo; e.tq = tq;
    exp_q.push_back(e);
  endtask

  task automatic compare(input ev_t o);
    ev_t e;
    if (exp_q.size() == 0) begin
      nvec++;
      nmis++;
      $display("FAIL unexpected_event: got kind %0d grant %0d, expected none (t=%0t)",
               o.kind, o.grant, $time);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", o.kind, e.kind);
      chk("ev_grant", o.grant, e.grant);
      if (e.len >= 0) chk("ev_len", o.len, e.len);
      if (e.gap >= 0) chk("ev_gap", o.gap, e.gap);
      if (e.kind == 1) begin
        chk("ev_timeout", o.tmo, e.tmo);
        chk("ev_timeout_q", o.tq, e.tq);
      end
    end
  endtask

  logic [3:0] prev_grant = 4'b0000;
  int         run_len = 0;
  int         gap_len = 1;

  // Monitor: watches the grant bus every cycle and reports start/end events.
  always @(negedge clk) begin
    ev_t o;
    if (mon_on) begin
      chk("busy_vs_grant", int'(tx_busy), int'(|tx_grant));
      chk("grant_onehot0", int'($onehot0(tx_grant)), 1);
      if (!tx_timeout) chk("timeout_q_zero", int'(tx_timeout_q), 0);
      if (tx_grant != 4'b0000 && prev_grant == 4'b0000) begin
        o.kind = 0; o.grant = int'(tx_grant); o.len = 0; o.gap = gap_len;
        o.tmo = int'(tx_timeout); o.tq = 0;
        compare(o);
        run_len = 1;
      end else if (tx_grant != 4'b0000) begin
        chk("grant_hold", int'(tx_grant), int'(prev_grant));
        chk("timeout_in_grant", int'(tx_timeout), 0);
        run_len++;
      end else if (prev_grant != 4'b0000) begin
        o.kind = 1; o.grant = int'(prev_grant); o.len = run_len; o.gap = 0;
        o.tmo = int'(tx_timeout); o.tq = int'(tx_timeout_q);
        compare(o);
        gap_len = 1;
      end else begin
        chk("stray_timeout", int'(tx_timeout), 0);
        gap_len++;
      end
      prev_grant = tx_grant;
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for tx_busy; c = cycles taken, maxc+1 if the budget expired.
  task automatic wait_grant(input int maxc, output int c);
    bit ok;
    ok = 1'b0;
    c  = maxc + 1;
    for (int i = 1; i <= maxc && !ok; i++) begin
      @(posedge clk);
      #1;
      if (tx_busy) begin
        ok = 1'b1;
        c  = i;
      end
    end
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL grant_wait: got no grant within %0d cycles, expected a grant", maxc);
    end
  endtask

  // Pulses tx_done after n further grant cycles; grant lasts n+1 cycles.
  task automatic grant_done(input int n);
    cyc(n);
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1; enable = 1'b0; tx_req = 4'b0000; tx_done = 1'b0;
    cyc(3);
    reset = 1'b0;
    chk("rst_grant", int'(tx_grant), 0);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_timeout", int'(tx_timeout), 0);
    chk("rst_timeout_q", int'(tx_timeout_q), 0);
    mon_on = 1'b1;

    // Round robin over all four queues, wrapping back to queue 0
    enable = 1'b1;
    push(0, 1, -1, -1, 0, 0);
    push(1, 1, 3, -1, 0, 0);
    for (int k = 1; k < 5; k++) begin
      push(0, 1 << (k % 4), -1, 1, 0, 0);
      push(1, 1 << (k % 4), 3, -1, 0, 0);
    end
    tx_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4, c);
      grant_done(2);
    end
    tx_req = 4'b0000;
    cyc(2);

    // Watchdog expiry on queue 2
    push(0, 4, -1, -1, 0, 0);
    push(1, 4, 16, -1, 1, 2);
    tx_req = 4'b0100;
    wait_grant(4, c);
    chk("req_latency", c, 1);
    cyc(16);
    tx_req = 4'b0000;
    cyc(2);

    // tx_done coincides with watchdog reaching zero
    push(0, 8, -1, -1, 0, 0);
    push(1, 8, 16, -1, 0, 0);
    tx_req = 4'b1000;
    wait_grant(4, c);
    tx_req = 4'b0000;
    grant_done(15);
    cyc(2);

    // enable gating, then request drop during grant, then wrap after last_q=1
    enable = 1'b0;
    tx_req = 4'b0011;
    cyc(5);
    enable = 1'b1;
    push(0, 1, -1, -1, 0, 0);
    push(1, 1, 2, -1, 0, 0);
    push(0, 2, -1, 1, 0, 0);
    push(1, 2, 7, -1, 0, 0);
    wait_grant(4, c);
    chk("enable_latency", c, 1);
    grant_done(1);
    wait_grant(4, c);
    tx_req = 4'b0000;
    grant_done(6);
    tx_req = 4'b0011;
    push(0, 1, -1, 1, 0, 0);
    push(1, 1, 3, -1, 0, 0);
    wait_grant(4, c);
    chk("wrap_latency", c, 1);
    enable = 1'b0;
    grant_done(2);
    cyc(4);
    tx_req = 4'b0000;
    enable = 1'b1;
    cyc(2);

    // Reset in the 5th grant cycle; stale tx_done afterwards is ignored
    push(0, 4, -1, -1, 0, 0);
    push(1, 4, 5, -1, 0, 0);
    push(0, 2, -1, -1, 0, 0);
    push(1, 2, 1, -1, 0, 0);
    tx_req = 4'b0100;
    wait_grant(4, c);
    cyc(4);
    reset  = 1'b1;
    tx_req = 4'b0000;
    cyc(1);
    reset   = 1'b0;
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    tx_req  = 4'b1010;
    wait_grant(4, c);
    chk("post_reset_latency", c, 1);
    tx_req = 4'b0000;
    grant_done(0);
    cyc(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cpu_dma_tx_sched.md
CPU_DMA_TX_SCHED -- requirements
Module: cpu_dma_tx_sched

Interface
REQ-001 Parameter NUM_QUEUES, default 4: number of CPU DMA TX queues sharing the DMA TX engine (2..16).
REQ-002 Parameter TX_WATCHDOG_TIMEOUT, default 125000: maximum cycles a grant may be held without tx_done (>=2).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  when low, no new grant is issued.
REQ-006 tx_req  input  NUM_QUEUES  per-queue level request: packet ready for DMA TX.
REQ-007 tx_done  input  1  one-cycle pulse from DMA engine: granted transfer complete.
REQ-008 tx_grant  output  NUM_QUEUES  one-hot (or zero) grant to the selected queue, registered.
REQ-009 tx_busy  output  1  high whenever tx_grant is non-zero.
REQ-010 tx_timeout  output  1  one-cycle pulse: watchdog expired on the current grant.
REQ-011 tx_timeout_q  output  log2(NUM_QUEUES)  index of the queue that timed out; valid only while tx_timeout=1, otherwise 0.

Function
REQ-012 FSM states: IDLE, ACTIVE; each state change takes exactly one clock.
REQ-013 IDLE: if enable=1 and tx_req!=0, select a winner and enter ACTIVE; tx_grant shows the winner's one-hot bit from the next cycle (grant latency 1 cycle from sampled request).
REQ-014 Arbitration is round-robin: search starts at index (last_q+1) mod NUM_QUEUES and wraps; first requesting index wins.
REQ-015 last_q updates to the winner index when a grant is issued; last_q resets to NUM_QUEUES-1, so queue 0 has first priority after reset.
REQ-016 ACTIVE: tx_grant held constant regardless of tx_req changes (dropping tx_req does not revoke the grant).
REQ-017 ACTIVE with tx_done=1: next cycle tx_grant=0, state IDLE, no timeout.
REQ-018 Watchdog: loaded to TX_WATCHDOG_TIMEOUT-1 on grant issue; decrements each ACTIVE cycle; counter width log2(TX_WATCHDOG_TIMEOUT)+1, no wrap.
REQ-019 ACTIVE, watchdog=0 and tx_done=0: next cycle tx_grant=0, tx_timeout=1, tx_timeout_q=granted index, state IDLE; tx_grant is therefore high for exactly TX_WATCHDOG_TIMEOUT cycles.
REQ-020 tx_done and watchdog=0 in the same cycle: tx_done wins; no tx_timeout.
REQ-021 tx_done while IDLE: ignored, no state change.
REQ-022 Minimum one IDLE cycle between consecutive grants (tx_grant low for >=1 cycle after release).
REQ-023 enable deasserted during ACTIVE: current grant continues to tx_done or timeout; no new grant until enable=1.
REQ-024 tx_grant has at most one bit set in every cycle; tx_busy = |tx_grant.

Reset
REQ-025 On reset: state IDLE, tx_grant=0, tx_busy=0, tx_timeout=0, tx_timeout_q=0, watchdog=0, last_q=NUM_QUEUES-1.
REQ-026 Reset asserted during ACTIVE: tx_grant=0 in the cycle following the reset edge; no tx_timeout is generated; pending tx_done after reset is ignored.

Verification (bench uses NUM_QUEUES=4, TX_WATCHDOG_TIMEOUT=16)
REQ-027 After reset, tx_req=4'b1111, tx_done 3 cycles after each grant -> grants 0001,0010,0100,1000,0001 in order, each separated by one idle cycle.
REQ-028 tx_req=4'b0100 held, no tx_done -> tx_grant=0100 for exactly 16 cycles, then tx_grant=0, tx_timeout=1 for one cycle with tx_timeout_q=2.
REQ-029 tx_done asserted in the 16th grant cycle (watchdog=0) -> grant released next cycle, tx_timeout stays 0.
REQ-030 enable=0 with tx_req=4'b0011 -> tx_grant stays 0; enable=1 -> grant 0001 one cycle later.
REQ-031 Grant 0010 active, tx_req drops to 0 -> tx_grant stays 0010 until tx_done; then last_q=1, next request set 4'b0011 -> grant 0001 (wrap after 2,3 absent).
REQ-032 reset pulsed 5 cycles into a grant -> tx_grant=0 next cycle, no tx_timeout, next grant goes to lowest requesting index.
